// File: rtl/bin_to_bcd_n.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Results are registered on completion so intermediate digits never reach the outputs.
module bin_to_bcd_n #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      opnd_q, opnd_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [DIGITS-1:0]     blank_q, blank_d;

    logic [DIGITS-1:0][3:0] adj;
    logic [4*DIGITS-1:0]    dig_shift;
    logic                   carry_out;
    logic [DIGITS-1:0]      blank_n;
    logic                   all_zero;
    logic                   last_shift;

    assign last_shift = (cnt_q == LAST_CNT);

    // One double-dabble step: correct each digit, then shift the chain left.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            adj[i] = (dig_q[4*i +: 4] > 4'd4) ? dig_q[4*i +: 4] + 4'd3 : dig_q[4*i +: 4];
        end
        dig_shift[3:0] = {adj[0][2:0], opnd_q[WIDTH-1]};
        for (int i = 1; i < DIGITS; i++) begin
            dig_shift[4*i +: 4] = {adj[i][2:0], adj[i-1][3]};
        end
        carry_out = adj[DIGITS-1][3];
    end

    // Leading-zero mask of the post-shift digits; digit 0 is never blanked.
    always_comb begin
        all_zero = 1'b1;
        blank_n  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (dig_shift[4*i +: 4] == 4'd0);
            blank_n[i] = (i > 0) & all_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONVERT;
            CONVERT: if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opnd_d  = opnd_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        blank_d = blank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = in;
                    dig_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
            CONVERT: begin
                opnd_d  = opnd_q << 1;
                dig_d   = dig_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = carry_q | carry_out;
                if (last_shift) begin
                    bcd_d   = dig_shift;
                    ovf_d   = carry_q | carry_out;
                    blank_d = blank_n;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_n.sv
// Bench for bin_to_bcd_n: default instance (14 bits / 4 digits) and a
// small instance (8 bits / 3 digits) checked against a decimal reference model.
module tb_bin_to_bcd_n;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [13:0] in_a = '0;
    logic [7:0]  in_b = '0;
    logic        ready_a, done_a, ovf_a, ready_b, done_b, ovf_b;
    logic [15:0] bcd_a;
    logic [3:0]  blank_a;
    logic [11:0] bcd_b;
    logic [2:0]  blank_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bin_to_bcd_n dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in(in_a),
        .ready(ready_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .blank(blank_a)
    );

    bin_to_bcd_n #(.WIDTH(8), .DIGITS(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in(in_b),
        .ready(ready_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .blank(blank_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain decimal arithmetic on the operand.
    function automatic void model(input longint v, input int d,
                                  output logic [39:0] b, output logic ov, output logic [9:0] bl);
        longint m = 1;
        longint r;
        int dg [10];
        bit allz = 1;
        for (int i = 0; i < d; i++) m = m * 10;
        ov = (v >= m);
        r = v % m;
        b = '0;
        bl = '0;
        for (int i = 0; i < d; i++) begin
            dg[i] = int'(r % 10);
            r = r / 10;
            b[4*i +: 4] = 4'(dg[i]);
        end
        for (int i = d - 1; i >= 1; i--) begin
            allz = allz && (dg[i] == 0);
            bl[i] = allz;
        end
    endfunction

    // Drives one conversion on dut_a and records what it observed.
    task automatic run_a(input logic [13:0] v, input bit poke,
                         output int lat, output int ndone, output bit held_ok,
                         output logic rdy_after, output logic [15:0] b,
                         output logic ov, output logic [3:0] bl);
        logic [15:0] prev;
        @(negedge clk);
        prev = bcd_a;
        in_a = v;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        lat = 0; ndone = 0; held_ok = 1; rdy_after = 1'b0;
        b = 'x; ov = 1'bx; bl = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (poke && c == 5) begin start_a = 1'b1; in_a = ~v; end
            if (poke && c == 7) start_a = 1'b0;
            if (done_a) begin
                ndone++;
                if (lat == 0) begin lat = c; b = bcd_a; ov = ovf_a; bl = blank_a; end
            end else if (lat == 0 && (bcd_a !== prev || ready_a !== 1'b0)) begin
                held_ok = 0;
            end
            if (lat != 0 && c == lat + 1) rdy_after = ready_a;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready_a, done_a, bcd_a, ovf_a, blank_a} !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL reset_a: got rdy=%b done=%b bcd=%h ov=%b blank=%b want 1 0 0000 0 0000",
                     ready_a, done_a, bcd_a, ovf_a, blank_a);
        end
        checks++;
        if ({ready_b, done_b, bcd_b, ovf_b, blank_b} !== {1'b1, 1'b0, 12'h0, 1'b0, 3'h0}) begin
            failures++;
            $display("FAIL reset_b: got rdy=%b done=%b bcd=%h ov=%b blank=%b want 1 0 000 0 000",
                     ready_b, done_b, bcd_b, ovf_b, blank_b);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [13:0] vals [5] = '{14'd9999, 14'd12345, 14'd16383, 14'd0, 14'd42};
        logic [15:0] eb   [5] = '{16'h9999, 16'h2345, 16'h6383, 16'h0000, 16'h0042};
        logic        eo   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  el   [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1100};
        int lat, nd; bit held; logic ra; logic [15:0] b; logic ov; logic [3:0] bl;
        for (int i = 0; i < 5; i++) begin
            run_a(vals[i], 0, lat, nd, held, ra, b, ov, bl);
            checks++;
            if (lat !== 14 || nd !== 1 || ra !== 1'b1 || !held) begin
                failures++;
                $display("FAIL timing_%0d: lat=%0d ndone=%0d ready_after=%b held=%0d want 14 1 1 1",
                         vals[i], lat, nd, ra, held);
            end
            checks++;
            if (b !== eb[i] || ov !== eo[i] || bl !== el[i]) begin
                failures++;
                $display("FAIL result_%0d: bcd=%h ov=%b blank=%b want %h %b %b",
                         vals[i], b, ov, bl, eb[i], eo[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, nd; bit held; logic ra; logic [15:0] b; logic ov; logic [3:0] bl;
        logic [39:0] mb; logic mo; logic [9:0] ml;
        logic [13:0] v;
        for (int i = 0; i < 20; i++) begin
            v = 14'($urandom_range(0, 16383));
            model(longint'(v), 4, mb, mo, ml);
            run_a(v, 0, lat, nd, held, ra, b, ov, bl);
            checks++;
            if (b !== mb[15:0] || ov !== mo || bl !== ml[3:0] || lat !== 14 || nd !== 1) begin
                failures++;
                $display("FAIL random_%0d: bcd=%h ov=%b blank=%b lat=%0d nd=%0d want %h %b %b 14 1",
                         v, b, ov, bl, lat, nd, mb[15:0], mo, ml[3:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, nd; bit held; logic ra; logic [15:0] b; logic ov; logic [3:0] bl;
        run_a(14'd9999, 1, lat, nd, held, ra, b, ov, bl);
        checks++;
        if (b !== 16'h9999 || ov !== 1'b0 || nd !== 1 || lat !== 14) begin
            failures++;
            $display("FAIL ignore_start: bcd=%h ov=%b ndone=%0d lat=%0d want 9999 0 1 14", b, ov, nd, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd; bit held; logic ra; logic [15:0] b; logic ov; logic [3:0] bl;
        int ndone = 0;
        @(negedge clk);
        in_a = 14'd9999;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ready_a, done_a, bcd_a, ovf_a, blank_a} !== {1'b1, 1'b0, 16'h0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL reset_mid: rdy=%b done=%b bcd=%h ov=%b blank=%b want 1 0 0000 0 0000",
                     ready_a, done_a, bcd_a, ovf_a, blank_a);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 if (done_a) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_no_done: done pulses=%0d want 0", ndone);
        end
        run_a(14'd1, 0, lat, nd, held, ra, b, ov, bl);
        checks++;
        if (b !== 16'h0001 || ov !== 1'b0 || bl !== 4'b1110 || lat !== 14) begin
            failures++;
            $display("FAIL after_reset: bcd=%h ov=%b blank=%b lat=%0d want 0001 0 1110 14", b, ov, bl, lat);
        end
    endtask

    // Small instance: start held high, sweep every operand, period must be WIDTH+2.
    task automatic test_back_to_back();
        logic [39:0] mb; logic mo; logic [9:0] ml;
        int last_done = -1;
        int waited;
        @(negedge clk);
        in_b = 8'd0;
        start_b = 1'b1;
        for (int v = 0; v < 256; v++) begin
            waited = 0;
            do begin
                @(posedge clk);
                #1 waited++;
            end while (!done_b && waited < 30);
            checks++;
            if (!done_b) begin
                failures++;
                $display("FAIL b2b_timeout_%0d: no done within %0d cycles", v, waited);
                break;
            end
            model(longint'(v), 3, mb, mo, ml);
            if (bcd_b !== mb[11:0] || ovf_b !== 1'b0 || blank_b !== ml[2:0]) begin
                failures++;
                $display("FAIL b2b_%0d: bcd=%h ov=%b blank=%b want %h 0 %b",
                         v, bcd_b, ovf_b, blank_b, mb[11:0], ml[2:0]);
            end
            if (last_done >= 0) begin
                checks++;
                if (cyc - last_done != 10) begin
                    failures++;
                    $display("FAIL b2b_period_%0d: period=%0d want 10", v, cyc - last_done);
                end
            end
            last_done = cyc;
            in_b = 8'(v + 1);
        end
        start_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
